// File: rtl/fighter_gfx_pkg.sv
// Shared types and constants for the fighter sprite engine: colour key,
// animation FSM states and the debug view exported by the top level.
package fighter_gfx_pkg;

    localparam logic [3:0] KEY_R = 4'hF;
    localparam logic [3:0] KEY_G = 4'h0;
    localparam logic [3:0] KEY_B = 4'hF;

    localparam int SCALE_MAX = 3;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } anim_state_t;

    // Debug view: animation FSM state plus the palette index behind the current pixel.
    typedef struct packed {
        anim_state_t state;
        logic [3:0]  pix_index;
    } fse_dbg_t;

    function automatic logic is_key(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return (r == KEY_R) && (g == KEY_G) && (b == KEY_B);
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: steps through NUM_FRAMES frames, each held for
// HOLD_TICKS frame_tick pulses, looping or playing once.
module sprite_anim_ctrl
    import fighter_gfx_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_TICKS = 6,
    parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick_i,
    input  logic               anim_start_i,
    input  logic               anim_loop_i,
    output logic [FRAME_W-1:0] anim_frame_o,
    output logic               anim_busy_o,
    output logic               anim_done_o,
    output anim_state_t        state_o
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    anim_state_t        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        // A start pulse overrides any tick arriving in the same cycle.
        if (anim_start_i) begin
            state_d = PLAY;
            frame_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_d = '0;
                    hold_d  = '0;
                end
                PLAY: begin
                    if (frame_tick_i) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d = '0;
                            if (frame_q == FRAME_LAST) begin
                                frame_d = '0;
                                if (!anim_loop_i) begin
                                    state_d = IDLE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                frame_d = frame_q + 1'b1;
                            end
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    frame_d = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign anim_frame_o = frame_q;
    assign anim_busy_o  = (state_q == PLAY);
    assign anim_done_o  = done_q;
    assign state_o      = state_q;

endmodule

// File: rtl/fighter_sprite_engine.sv
// Fighter sprite renderer: maps the VGA pixel into a multi-frame sprite ROM with
// power-of-two scaling, mirroring and colour-key transparency; latency ROM_LAT+2.
module fighter_sprite_engine
    import fighter_gfx_pkg::*;
#(
    parameter int SPR_W       = 92,
    parameter int SPR_H       = 120,
    parameter int SCALE_SHIFT = 1,
    parameter int NUM_FRAMES  = 4,
    parameter int HOLD_TICKS  = 6,
    parameter int ROM_LAT     = 1,
    parameter int ADDR_W      = $clog2(SPR_W * SPR_H * NUM_FRAMES),
    parameter int FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [9:0]         PosX,
    input  logic [9:0]         PosY,
    input  logic               blank,
    input  logic               frame_tick,
    input  logic               anim_start,
    input  logic               anim_loop,
    input  logic               facing_left,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [3:0]         rom_q,
    input  logic [3:0]         pal_r,
    input  logic [3:0]         pal_g,
    input  logic [3:0]         pal_b,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               sprite_on,
    output logic [FRAME_W-1:0] anim_frame,
    output logic               anim_busy,
    output logic               anim_done,
    output fse_dbg_t           dbg
);

    localparam int S         = (SCALE_SHIFT > SCALE_MAX) ? SCALE_MAX : SCALE_SHIFT;
    localparam int FRAME_PIX = SPR_W * SPR_H;

    anim_state_t        anim_state;
    logic [FRAME_W-1:0] frame_lat_q;
    logic [ADDR_W-1:0]  rom_address_q, addr_d;
    logic [ROM_LAT:0]   vis_q;
    logic [3:0]         red_q, green_q, blue_q, pix_idx_q;
    logic               sprite_on_q, pix_on;
    logic [10:0]        x_end, y_end;
    logic [9:0]         dx, dy, sx, sy;
    logic               hit;

    sprite_anim_ctrl #(
        .NUM_FRAMES (NUM_FRAMES),
        .HOLD_TICKS (HOLD_TICKS),
        .FRAME_W    (FRAME_W)
    ) u_anim (
        .clk          (vga_clk),
        .rst          (reset),
        .frame_tick_i (frame_tick),
        .anim_start_i (anim_start),
        .anim_loop_i  (anim_loop),
        .anim_frame_o (anim_frame),
        .anim_busy_o  (anim_busy),
        .anim_done_o  (anim_done),
        .state_o      (anim_state)
    );

    // 11-bit box bounds so a sprite near the right/bottom edge never wraps to column 0.
    always_comb begin
        x_end = {1'b0, PosX} + 11'(SPR_W << S);
        y_end = {1'b0, PosY} + 11'(SPR_H << S);
        hit   = ({1'b0, DrawX} >= {1'b0, PosX}) && ({1'b0, DrawX} < x_end) &&
                ({1'b0, DrawY} >= {1'b0, PosY}) && ({1'b0, DrawY} < y_end);
        dx    = DrawX - PosX;
        dy    = DrawY - PosY;
        sx    = dx >> S;
        sy    = dy >> S;
        if (facing_left) begin
            sx = 10'(SPR_W - 1) - sx;
        end
        addr_d = '0;
        if (hit) begin
            addr_d = ADDR_W'(frame_lat_q) * ADDR_W'(FRAME_PIX)
                   + ADDR_W'(sy) * ADDR_W'(SPR_W)
                   + ADDR_W'(sx);
        end
    end

    assign pix_on = vis_q[ROM_LAT] && !is_key(pal_r, pal_g, pal_b);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address_q <= '0;
            frame_lat_q   <= '0;
            vis_q         <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            pix_idx_q     <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            rom_address_q <= addr_d;
            // Frame only changes outside active video so a sprite never tears mid-frame.
            if (!blank) begin
                frame_lat_q <= anim_frame;
            end
            vis_q       <= {vis_q[ROM_LAT-1:0], hit & blank};
            sprite_on_q <= pix_on;
            red_q       <= pix_on ? pal_r : 4'h0;
            green_q     <= pix_on ? pal_g : 4'h0;
            blue_q      <= pix_on ? pal_b : 4'h0;
            pix_idx_q   <= pix_on ? rom_q : 4'h0;
        end
    end

    assign rom_address = rom_address_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign sprite_on   = sprite_on_q;

    always_comb begin
        dbg           = '0;
        dbg.state     = anim_state;
        dbg.pix_index = pix_idx_q;
    end

endmodule

// File: tb/tb_fighter_sprite_engine.sv
// Self-checking bench for fighter_sprite_engine with default parameters
// (92x120 sprite, 2x scale, 4 frames x 6 ticks, ROM latency 1).
module tb_fighter_sprite_engine;
    import fighter_gfx_pkg::*;

    localparam int AW = 16;
    localparam int EW = 33;

    logic          vga_clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
    logic          blank = 1'b0, frame_tick = 1'b0, anim_start = 1'b0;
    logic          anim_loop = 1'b0, facing_left = 1'b0;
    logic [AW-1:0] rom_address;
    logic [3:0]    rom_q = 4'h0;
    logic [3:0]    pal_r, pal_g, pal_b, red, green, blue;
    logic          sprite_on, anim_busy, anim_done;
    logic [1:0]    anim_frame;
    fse_dbg_t      dbg;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        int            x, y, px, py;
        logic          bl, fl;
        logic [AW-1:0] addr;
        logic          on;
    } vec_t;
    vec_t vt[15];

    always #5 vga_clk = ~vga_clk;

    fighter_sprite_engine dut (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(DrawX), .DrawY(DrawY), .PosX(PosX), .PosY(PosY),
        .blank(blank), .frame_tick(frame_tick), .anim_start(anim_start),
        .anim_loop(anim_loop), .facing_left(facing_left),
        .rom_address(rom_address), .rom_q(rom_q),
        .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
        .red(red), .green(green), .blue(blue), .sprite_on(sprite_on),
        .anim_frame(anim_frame), .anim_busy(anim_busy), .anim_done(anim_done),
        .dbg(dbg)
    );

    // External ROM (latency 1) and combinational palette models.
    function automatic logic [3:0] rom_fn(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    function automatic logic [11:0] pal_of(input logic [3:0] i);
        if (i == 4'h9) return 12'hF0F;
        if (i == 4'h3) return 12'h37A;
        return {i, ~i, i + 4'd3};
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(rom_address);
    assign {pal_r, pal_g, pal_b} = pal_of(rom_q);

    always @(negedge vga_clk) if (anim_done) done_cnt++;

    // Returns {hit, address} for frame 0..3 at 2x scale.
    function automatic logic [AW:0] model(input int x, input int y, input int px, input int py,
                                          input logic fl, input int frame);
        int sx, sy;
        if (!(x >= px && x < px + 184 && y >= py && y < py + 240)) return '0;
        sx = (x - px) / 2;
        sy = (y - py) / 2;
        if (fl) sx = 91 - sx;
        return {1'b1, AW'(frame * 11040 + sy * 92 + sx)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [EW-1:0] e;
        @(posedge vga_clk);
        cyc++;
        #1;
        while (exp_q.size() > 0 && exp_q[0][32:17] == 16'(cyc)) begin
            e = exp_q.pop_front();
            check("sprite_on", 32'(sprite_on), 32'(e[16]));
            check("pix_index", 32'(dbg.pix_index), 32'(e[15:12]));
            check("rgb", 32'({red, green, blue}), 32'(e[11:0]));
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic drive_pixel(input int x, input int y, input int px, input int py,
                               input logic bl, input logic fl,
                               input logic [AW-1:0] ea, input logic eon);
        logic [3:0]  idx;
        logic [11:0] rgb;
        DrawX = 10'(x); DrawY = 10'(y); PosX = 10'(px); PosY = 10'(py);
        blank = bl; facing_left = fl;
        step();
        check("rom_address", 32'(rom_address), 32'(ea));
        idx = eon ? rom_fn(ea) : 4'h0;
        rgb = eon ? pal_of(idx) : 12'h0;
        exp_q.push_back({16'(cyc + 2), eon, idx, rgb});
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW:0]   m;
        logic          on;
        int            x, y, px, py;
        logic          bl, fl;

        vt[0]  = '{100, 50, 100, 50, 1'b1, 1'b0, 16'd0,     1'b1};
        vt[1]  = '{283, 289, 100, 50, 1'b1, 1'b0, 16'd11039, 1'b1};
        vt[2]  = '{284, 289, 100, 50, 1'b1, 1'b0, 16'd0,     1'b0};
        vt[3]  = '{100, 50, 100, 50, 1'b1, 1'b1, 16'd91,    1'b1};
        vt[4]  = '{118, 50, 100, 50, 1'b1, 1'b0, 16'd9,     1'b0};
        vt[5]  = '{106, 50, 100, 50, 1'b1, 1'b0, 16'd3,     1'b1};
        vt[6]  = '{99,  50, 100, 50, 1'b1, 1'b0, 16'd0,     1'b0};
        vt[7]  = '{100, 49, 100, 50, 1'b1, 1'b0, 16'd0,     1'b0};
        vt[8]  = '{283, 50, 100, 50, 1'b1, 1'b0, 16'd91,    1'b1};
        vt[9]  = '{283, 290, 100, 50, 1'b1, 1'b0, 16'd0,     1'b0};
        vt[10] = '{150, 100, 100, 50, 1'b0, 1'b0, 16'd2325,  1'b0};
        vt[11] = '{283, 289, 100, 50, 1'b1, 1'b1, 16'd10948, 1'b1};
        vt[12] = '{0,   0,   0,   0,  1'b1, 1'b0, 16'd0,     1'b1};
        vt[13] = '{1023, 1023, 900, 800, 1'b1, 1'b0, 16'd10273, 1'b1};
        vt[14] = '{5,   900, 900, 800, 1'b1, 1'b0, 16'd0,     1'b0};

        // Reset state
        repeat (3) step();
        check("reset_rom_address", 32'(rom_address), 0);
        check("reset_sprite_on", 32'(sprite_on), 0);
        check("reset_rgb", 32'({red, green, blue}), 0);
        check("reset_busy", 32'(anim_busy), 0);
        check("reset_frame", 32'(anim_frame), 0);
        check("reset_done", 32'(anim_done), 0);
        reset = 1'b0;
        step();
        check("post_reset_frame", 32'(anim_frame), 0);
        check("post_reset_state", 32'(dbg.state), 32'(IDLE));

        // Table-driven pixel vectors
        for (int i = 0; i < 15; i++) begin
            drive_pixel(vt[i].x, vt[i].y, vt[i].px, vt[i].py, vt[i].bl, vt[i].fl,
                        vt[i].addr, vt[i].on);
        end

        // Random pixel stream around the sprite box
        for (int i = 0; i < 40; i++) begin
            px = $urandom_range(4, 700);
            py = $urandom_range(4, 500);
            x  = px - 4 + $urandom_range(0, 192);
            y  = py - 4 + $urandom_range(0, 248);
            bl = ($urandom_range(0, 7) != 0);
            fl = 1'($urandom_range(0, 1));
            m  = model(x, y, px, py, fl, 0);
            on = m[AW] && bl && (pal_of(rom_fn(m[AW-1:0])) != 12'hF0F);
            drive_pixel(x, y, px, py, bl, fl, m[AW-1:0], on);
        end
        blank = 1'b0;
        repeat (3) step();
        check("queue_drain", 32'(exp_q.size()), 0);

        // Play-once animation: 4 frames x 6 ticks
        DrawX = 10'd0; DrawY = 10'd0; PosX = 10'd500; PosY = 10'd500;
        done_cnt = 0;
        anim_loop = 1'b0;
        anim_start = 1'b1;
        step();
        anim_start = 1'b0;
        check("start_frame", 32'(anim_frame), 0);
        check("start_busy", 32'(anim_busy), 1);
        check("start_state", 32'(dbg.state), 32'(PLAY));
        for (int t = 1; t <= 24; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (t < 24) begin
                if (t % 6 == 0 || t % 6 == 5) begin
                    check("once_frame", 32'(anim_frame), 32'(t / 6));
                    check("once_busy", 32'(anim_busy), 1);
                end
            end else begin
                check("once_done_pulse", 32'(anim_done), 1);
                check("once_end_busy", 32'(anim_busy), 0);
                check("once_end_frame", 32'(anim_frame), 0);
            end
            step();
        end
        check("once_done_clear", 32'(anim_done), 0);
        check("once_done_count", 32'(done_cnt), 1);
        check("once_end_state", 32'(dbg.state), 32'(IDLE));

        // Looping, with start coincident with a tick during frame 2
        anim_loop = 1'b1;
        anim_start = 1'b1;
        step();
        anim_start = 1'b0;
        repeat (15) tick();
        check("loop_frame2", 32'(anim_frame), 2);
        anim_start = 1'b1;
        frame_tick = 1'b1;
        step();
        anim_start = 1'b0;
        frame_tick = 1'b0;
        check("coincident_frame", 32'(anim_frame), 0);
        check("coincident_busy", 32'(anim_busy), 1);
        repeat (5) tick();
        check("coincident_hold_reset", 32'(anim_frame), 0);
        tick();
        check("coincident_advance", 32'(anim_frame), 1);
        repeat (17) tick();
        check("loop_frame3", 32'(anim_frame), 3);
        tick();
        check("loop_wrap_frame", 32'(anim_frame), 0);
        check("loop_wrap_busy", 32'(anim_busy), 1);
        check("loop_no_done", 32'(done_cnt), 1);
        repeat (6) tick();
        check("loop_frame1", 32'(anim_frame), 1);

        // Frame sampled into the address only during blanking
        blank = 1'b0;
        step();
        DrawX = 10'd100; DrawY = 10'd50; PosX = 10'd100; PosY = 10'd50;
        facing_left = 1'b0;
        blank = 1'b1;
        step();
        check("frame1_address", 32'(rom_address), 11040);
        repeat (6) tick();
        check("frame_advanced", 32'(anim_frame), 2);
        check("no_tearing_address", 32'(rom_address), 11040);
        check("opaque_before_reset", 32'(sprite_on), 1);

        // Reset asserted mid-line, mid-animation
        #2;
        reset = 1'b1;
        #1;
        check("midreset_sprite_on", 32'(sprite_on), 0);
        check("midreset_rgb", 32'({red, green, blue}), 0);
        check("midreset_rom_address", 32'(rom_address), 0);
        check("midreset_busy", 32'(anim_busy), 0);
        check("midreset_frame", 32'(anim_frame), 0);
        repeat (2) step();
        reset = 1'b0;
        blank = 1'b0;
        exp_q.delete();
        step();
        check("after_midreset_state", 32'(dbg.state), 32'(IDLE));
        check("after_midreset_frame", 32'(anim_frame), 0);
        check("midreset_no_done", 32'(done_cnt), 1);

        // Restart while playing
        anim_start = 1'b1;
        step();
        anim_start = 1'b0;
        repeat (7) tick();
        check("restart_pre_frame", 32'(anim_frame), 1);
        anim_start = 1'b1;
        step();
        anim_start = 1'b0;
        check("restart_frame", 32'(anim_frame), 0);
        check("restart_busy", 32'(anim_busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
